// File: rtl/spi_cfg_pkg.sv
// Shared constants, FSM state type and frame builder for the SPI configuration master.
package spi_cfg_pkg;

   localparam int   FRAME_W   = 16;
   localparam int   ADDR_W    = 7;
   localparam int   DATA_W    = 8;
   localparam logic WRITE_BIT = 1'b1;

   localparam logic [ADDR_W-1:0] ADDR_REG0 = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_REG1 = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_REG2 = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_REG3 = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_REG4 = 7'h04;

   typedef enum logic [2:0] {
      IDLE,
      REJECT,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
      return {WRITE_BIT, addr, data};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest valid index at or above ptr wins, else lowest valid overall.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [NUM_REQ-1:0] upper;

   always_comb begin
      upper = '0;
      gnt   = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         upper[i] = req[i] && (i >= 32'(ptr));
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!any && upper[i]) begin
            gnt[i] = 1'b1;
            idx    = IDX_W'(i);
            any    = 1'b1;
         end
      end
      // wrap-around: nothing valid at or above the pointer
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!any && req[i]) begin
            gnt[i] = 1'b1;
            idx    = IDX_W'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_cfg_master.sv
// Arbitrates register-write requests and serialises each into a 16-bit SPI mode-0 write frame.
module spi_cfg_master
   import spi_cfg_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int SCLK_DIV = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 2,
   parameter int IDLE_GAP = 2,
   parameter int MAX_ADDR = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      done,
   output logic                      err,
   output logic [2:0]                resp_id,
   output logic                      busy,
   output logic                      cs_n,
   output logic                      sclk,
   output logic                      copi
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 16;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, idx;
   logic [NUM_REQ-1:0] gnt;
   logic               any;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic [FRAME_W-1:0] shreg;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         bit_cnt;
   logic [2:0]         id_q;
   logic               grant, phase_end, shift_en, bit_adv, sclk_nxt;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (idx),
      .any (any)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      shift_en  = 1'b0;
      bit_adv   = 1'b0;
      phase_end = (state == SHIFT) && (cnt == CNT_W'(SCLK_DIV-1));
      unique case (state)
         IDLE: begin
            if (any) begin
               grant     = 1'b1;
               state_nxt = (sel_addr > ADDR_W'(MAX_ADDR)) ? REJECT : SETUP;
            end
         end
         REJECT: state_nxt = IDLE;
         SETUP:  if (cnt == CNT_W'(CS_SETUP-1)) state_nxt = SHIFT;
         SHIFT: begin
            if (phase_end) begin
               if (sclk)                  shift_en  = 1'b1;
               else if (bit_cnt == 4'd15) state_nxt = HOLD;
               else                       bit_adv   = 1'b1;
            end
         end
         HOLD:    if (cnt == CNT_W'(CS_HOLD-1))  state_nxt = GAP;
         GAP:     if (cnt == CNT_W'(IDLE_GAP-1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      sclk_nxt = 1'b0;
      if (state_nxt == SHIFT) begin
         if (state != SHIFT) sclk_nxt = 1'b1;
         else if (phase_end) sclk_nxt = ~sclk;
         else                sclk_nxt = sclk;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         id_q    <= '0;
         shreg   <= '0;
         cnt     <= '0;
         bit_cnt <= '0;
         cs_n    <= 1'b1;
         sclk    <= 1'b0;
      end else begin
         state <= state_nxt;
         sclk  <= sclk_nxt;
         cs_n  <= !(state_nxt inside {SETUP, SHIFT, HOLD});
         if (state == IDLE || state_nxt != state || phase_end) cnt <= '0;
         else                                                  cnt <= cnt + 1'b1;
         if (grant) begin
            ptr     <= (32'(idx) == NUM_REQ-1) ? '0 : idx + 1'b1;
            id_q    <= 3'(idx);
            bit_cnt <= '0;
            if (state_nxt == SETUP) shreg <= make_frame(sel_addr, sel_data);
         end
         // zero-fill keeps copi low once the last bit has gone out
         if (shift_en) shreg <= {shreg[FRAME_W-2:0], 1'b0};
         if (bit_adv)  bit_cnt <= bit_cnt + 4'd1;
      end
   end

   assign copi      = shreg[FRAME_W-1];
   assign req_ready = grant ? gnt : '0;
   assign done      = (state == HOLD) && (cnt == CNT_W'(CS_HOLD-1));
   assign err       = (state == REJECT);
   assign resp_id   = (done || err) ? id_q : '0;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed self-checking bench: a default-timing instance plus a minimum-timing instance.
module tb_spi_cfg_master;
   import spi_cfg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, f_req_valid, f_req_ready;
   logic [13:0] req_addr, f_req_addr;
   logic [15:0] req_data, f_req_data;
   logic        done, err, busy, cs_n, sclk, copi;
   logic        f_done, f_err, f_busy, f_cs_n, f_sclk, f_copi;
   logic [2:0]  resp_id, f_resp_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_cfg_master #(.NUM_REQ(2), .SCLK_DIV(4), .CS_SETUP(4), .CS_HOLD(2), .IDLE_GAP(2), .MAX_ADDR(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .done(done), .err(err), .resp_id(resp_id), .busy(busy),
      .cs_n(cs_n), .sclk(sclk), .copi(copi)
   );

   spi_cfg_master #(.NUM_REQ(2), .SCLK_DIV(3), .CS_SETUP(3), .CS_HOLD(2), .IDLE_GAP(2), .MAX_ADDR(4)) dut_fast (
      .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid), .req_addr(f_req_addr), .req_data(f_req_data),
      .req_ready(f_req_ready), .done(f_done), .err(f_err), .resp_id(f_resp_id), .busy(f_busy),
      .cs_n(f_cs_n), .sclk(f_sclk), .copi(f_copi)
   );

   // peripheral model for the default instance
   typedef struct { logic [15:0] frame; int bits; int low; } frame_t;
   frame_t      frames[$];
   logic [15:0] mon_sh;
   int          mon_bits = 0, min_gap = 1000, min_stab = 1000, done_cnt = 0;
   time         t_fall, t_rise, t_copi;
   bit          have_rise = 0;

   always @(negedge cs_n) begin
      mon_sh = '0; mon_bits = 0; t_fall = $time;
      if (have_rise && int'(($time - t_rise) / 10) < min_gap) min_gap = int'(($time - t_rise) / 10);
   end
   always @(posedge sclk) if (!cs_n) begin
      mon_sh = {mon_sh[14:0], copi}; mon_bits++;
      if (int'(($time - t_copi) / 10) < min_stab) min_stab = int'(($time - t_copi) / 10);
   end
   always @(copi) t_copi = $time;
   always @(posedge cs_n) begin
      frames.push_back('{mon_sh, mon_bits, int'(($time - t_fall) / 10)});
      t_rise = $time; have_rise = 1;
   end
   always @(posedge clk) if (done) done_cnt++;

   // peripheral model for the minimum-timing instance
   logic [15:0] f_sh, f_frame;
   int          f_bits = 0, f_nbits = 0, f_low = 0, f_min_stab = 1000;
   time         f_tfall, f_tcopi;
   always @(negedge f_cs_n) begin f_sh = '0; f_bits = 0; f_tfall = $time; end
   always @(posedge f_sclk) if (!f_cs_n) begin
      f_sh = {f_sh[14:0], f_copi}; f_bits++;
      if (int'(($time - f_tcopi) / 10) < f_min_stab) f_min_stab = int'(($time - f_tcopi) / 10);
   end
   always @(f_copi) f_tcopi = $time;
   always @(posedge f_cs_n) begin f_frame = f_sh; f_nbits = f_bits; f_low = int'(($time - f_tfall) / 10); end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d);
      req_addr[i*7 +: 7] = a;
      req_data[i*8 +: 8] = d;
   endtask

   task automatic wait_grant(input string tag, input logic [1:0] exp);
      logic [1:0] g;
      g = '0;
      for (int i = 0; i < 1000; i++) begin
         #1;
         if (req_ready != 2'b00) begin g = req_ready; break; end
         @(negedge clk);
      end
      check({tag, "_grant"}, 32'(g), 32'(exp));
   endtask

   task automatic wait_resp(input string tag, input logic [2:0] exp_id, input logic exp_err);
      logic seen, e;
      logic [2:0] id;
      seen = 0; e = 0; id = '0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk); #1;
         if (done || err) begin seen = 1; id = resp_id; e = err; end
      end
      check({tag, "_resp"}, 32'(seen), 1);
      check({tag, "_id"}, 32'(id), 32'(exp_id));
      check({tag, "_err"}, 32'(e), 32'(exp_err));
   endtask

   task automatic check_frame(input string tag, input logic [15:0] exp_frame);
      frame_t f;
      check({tag, "_avail"}, 32'(frames.size() > 0), 1);
      if (frames.size() > 0) begin
         f = frames.pop_front();
         check({tag, "_frame"}, 32'(f.frame), 32'(exp_frame));
         check({tag, "_bits"}, f.bits, 16);
         check({tag, "_low"}, f.low, 134);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_g[3];
      logic [2:0] exp_id[3];
      logic [15:0] exp_f[3];
      int dc;
      frame_t pf;

      rst_n = 1'b1;
      req_valid = '0; req_addr = '0; req_data = '0;
      f_req_valid = '0; f_req_addr = '0; f_req_data = '0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_cs_n", 32'(cs_n), 1);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_copi", 32'(copi), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_flags", 32'({req_ready, done, err, resp_id}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      frames.delete();

      // 1: single write
      @(negedge clk);
      req_valid = 2'b01; set_req(0, ADDR_REG2, 8'hA5);
      wait_grant("t1", 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check("t1_ready_drop", 32'(req_ready), 0);
      check("t1_cs_fall", 32'(cs_n), 0);
      check("t1_busy", 32'(busy), 1);
      wait_resp("t1", 3'd0, 1'b0);
      @(negedge clk); #1;
      check("t1_done_pulse", 32'(done), 0);
      @(negedge clk); #1;
      check("t1_busy_gap", 32'(busy), 1);
      @(negedge clk); #1;
      check("t1_busy_idle", 32'(busy), 0);
      check_frame("t1", 16'h82A5);

      // 2: contention with alternating pointer
      do_reset();
      @(negedge clk);
      set_req(0, ADDR_REG1, 8'h10); set_req(1, ADDR_REG3, 8'h31);
      req_valid = 2'b11;
      exp_g  = '{2'b01, 2'b10, 2'b01};
      exp_id = '{3'd0, 3'd1, 3'd0};
      exp_f  = '{16'h8110, 16'h8331, 16'h8110};
      for (int k = 0; k < 3; k++) begin
         wait_grant($sformatf("t2_%0d", k), exp_g[k]);
         if (k == 2) begin @(negedge clk); req_valid = 2'b00; end
         wait_resp($sformatf("t2_%0d", k), exp_id[k], 1'b0);
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) check_frame($sformatf("t2_%0d", k), exp_f[k]);

      // 3: illegal address rejected, pointer moves to 0
      @(negedge clk);
      req_valid = 2'b10; set_req(1, 7'h05, 8'h77);
      wait_grant("t3", 2'b10);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check("t3_err", 32'(err), 1);
      check("t3_id", 32'(resp_id), 1);
      check("t3_done", 32'(done), 0);
      check("t3_spi", 32'({cs_n, sclk}), 32'(2'b10));
      @(negedge clk); #1;
      check("t3_err_pulse", 32'(err), 0);
      check("t3_cs_after", 32'(cs_n), 1);
      check("t3_idle", 32'(busy), 0);
      check("t3_nframes", frames.size(), 0);
      set_req(0, ADDR_REG0, 8'h99); set_req(1, ADDR_REG2, 8'h33);
      req_valid = 2'b11;
      wait_grant("t3_ptr", 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      wait_resp("t3", 3'd0, 1'b0);
      repeat (3) @(negedge clk);
      check("t3_nframes_after", frames.size(), 1);
      check_frame("t3", 16'h8099);

      // 4: back-to-back writes to all registers
      have_rise = 0; min_gap = 1000;
      @(negedge clk);
      req_valid = 2'b01; set_req(0, ADDR_REG0, 8'h11);
      for (int k = 0; k < 5; k++) begin
         wait_grant($sformatf("t4_%0d", k), 2'b01);
         @(negedge clk);
         set_req(0, 7'(k + 1), 8'((k + 2) * 8'h11));
         if (k == 4) req_valid = 2'b00;
         wait_resp($sformatf("t4_%0d", k), 3'd0, 1'b0);
      end
      repeat (3) @(negedge clk);
      check_frame("t4_0", 16'h8011);
      check_frame("t4_1", 16'h8122);
      check_frame("t4_2", 16'h8233);
      check_frame("t4_3", 16'h8344);
      check_frame("t4_4", 16'h8455);
      check("t4_min_gap", 32'(min_gap >= 3), 1);
      check("t4_copi_stable", 32'(min_stab >= 4), 1);

      // 5: reset after the 7th sclk rise
      @(negedge clk);
      req_valid = 2'b01; set_req(0, ADDR_REG3, 8'h5A);
      wait_grant("t5", 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      for (int i = 0; i < 300 && mon_bits != 7; i++) begin @(negedge clk); #1; end
      check("t5_bits7", mon_bits, 7);
      check("t5_pre_sclk", 32'(sclk), 1);
      check("t5_pre_copi", 32'(copi), 1);
      dc = done_cnt;
      rst_n = 1'b0;
      #1;
      check("t5_cs_n", 32'(cs_n), 1);
      check("t5_sclk", 32'(sclk), 0);
      check("t5_copi", 32'(copi), 0);
      check("t5_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("t5_no_done", done_cnt, dc);
      check("t5_partial_n", frames.size(), 1);
      if (frames.size() > 0) begin
         pf = frames.pop_front();
         check("t5_partial_bits", pf.bits, 7);
      end
      set_req(0, ADDR_REG4, 8'hFF); set_req(1, ADDR_REG2, 8'h33);
      req_valid = 2'b11;
      wait_grant("t5_ptr", 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      wait_resp("t5", 3'd0, 1'b0);
      repeat (3) @(negedge clk);
      check_frame("t5", 16'h84FF);

      // 6: minimum SCLK_DIV / CS_SETUP timing
      f_min_stab = 1000;
      @(negedge clk);
      f_req_valid = 2'b01; f_req_addr[6:0] = ADDR_REG1; f_req_data[7:0] = 8'hC3;
      #1;
      check("t6_grant", 32'(f_req_ready), 1);
      @(negedge clk);
      f_req_valid = 2'b00;
      dc = 0;
      for (int i = 0; i < 500 && dc == 0; i++) begin
         @(negedge clk); #1;
         if (f_done) dc = 1;
      end
      check("t6_done", dc, 1);
      repeat (3) @(negedge clk);
      check("t6_frame", 32'(f_frame), 32'h81C3);
      check("t6_bits", f_nbits, 16);
      check("t6_low", f_low, 101);
      check("t6_copi_stable", 32'(f_min_stab >= 3), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
